// File: rtl/mmio_pkg.sv
// Shared types and default I/O addresses for the MMIO bridge.
// Address constants are 64 bits wide so any ADDR_W can take its low slice.
package mmio_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    ACK  = 2'd2
  } mmio_state_e;

  localparam logic [63:0] MMIO_SW_ADDR  = '1;
  localparam logic [63:0] MMIO_LED_ADDR = MMIO_SW_ADDR - 64'd1;
endpackage

// File: rtl/mmio_bridge_if.sv
// CPU request/ack and SRAM strobe bus for the MMIO bridge.
// The bridge uses slave; the CPU/memory side uses master.
interface mmio_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              mem_ce_n;
  logic              mem_oe_n;
  logic              mem_we_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ack, mem_ce_n, mem_oe_n, mem_we_n, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ack, mem_ce_n, mem_oe_n, mem_we_n, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mmio_bridge.sv
// CPU-to-SRAM bridge with switch/hex/LED registers decoded at fixed addresses.
// I/O accesses complete in one cycle; SRAM accesses hold strobes WAIT_STATES+1 cycles.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_HEX     = 4,
  parameter int LED_W       = 12,
  parameter int WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] SW_ADDR  = MMIO_SW_ADDR[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] HEX_ADDR = MMIO_SW_ADDR[ADDR_W-1:0],
  parameter logic [ADDR_W-1:0] LED_ADDR = MMIO_LED_ADDR[ADDR_W-1:0]
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmio_bridge_if.slave         bus,
  input  logic [DATA_W-1:0]    switches,
  output logic [4*NUM_HEX-1:0] hex_out,
  output logic [LED_W-1:0]     led
);
  localparam int HEX_W = 4 * NUM_HEX;
  localparam int CNT_W = $clog2(WAIT_STATES + 2);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MEM  = MEM;
  localparam logic [1:0] S_ACK  = ACK;

  logic [1:0]        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] sw_sync;
  logic              hit_sw, hit_hex, hit_led;
  logic [DATA_W-1:0] io_rdata;

  sync2 #(.WIDTH(DATA_W)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (switches),
    .q     (sw_sync)
  );

  // Decode uses the live address: it only matters in the IDLE sampling cycle.
  assign hit_sw  = (bus.cpu_addr == SW_ADDR);
  assign hit_hex = (bus.cpu_addr == HEX_ADDR);
  assign hit_led = (bus.cpu_addr == LED_ADDR);

  // Switches win reads on a shared address; hex wins writes.
  always_comb begin
    io_rdata = '0;
    if (hit_sw)       io_rdata = sw_sync;
    else if (hit_hex) io_rdata = DATA_W'(hex_out);
    else if (hit_led) io_rdata = DATA_W'(led);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      bus.cpu_rdata <= '0;
      hex_out       <= '0;
      led           <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.cpu_req) begin
          we_q    <= bus.cpu_we;
          addr_q  <= bus.cpu_addr;
          wdata_q <= bus.cpu_wdata;
          if (hit_sw || hit_hex || hit_led) begin
            state <= S_ACK;
            if (bus.cpu_we) begin
              if (hit_hex)      hex_out <= bus.cpu_wdata[HEX_W-1:0];
              else if (hit_led) led     <= bus.cpu_wdata[LED_W-1:0];
            end else begin
              bus.cpu_rdata <= io_rdata;
            end
          end else begin
            state    <= S_MEM;
            wait_cnt <= CNT_W'(WAIT_STATES);
          end
        end
        S_MEM: begin
          if (wait_cnt == '0) begin
            if (!we_q) bus.cpu_rdata <= bus.mem_rdata;
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_ack   = (state == S_ACK);
  assign bus.mem_ce_n  = (state != S_MEM);
  assign bus.mem_oe_n  = !((state == S_MEM) && !we_q);
  assign bus.mem_we_n  = !((state == S_MEM) && we_q);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed scenarios plus randomized traffic against a
// behavioural model of the SRAM and I/O registers. A second DUT uses WAIT_STATES=0.
module tb_mmio_bridge;
  localparam int WS = 1;
  localparam logic [15:0] SW_A  = 16'hFFFF;
  localparam logic [15:0] HEX_A = 16'hFFFF;
  localparam logic [15:0] LED_A = 16'hFFFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, cwe = 1'b0;
  logic [15:0] caddr = '0, cwdata = '0;
  logic [15:0] switches = '0;
  logic [15:0] hex_out, hex_out0;
  logic [11:0] led, led0;
  logic        sel = 1'b0;

  mmio_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  mmio_bridge_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

  mmio_bridge #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .switches(switches), .hex_out(hex_out), .led(led)
  );
  mmio_bridge #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .switches(switches), .hex_out(hex_out0), .led(led0)
  );

  assign bus.cpu_req    = req;
  assign bus.cpu_we     = cwe;
  assign bus.cpu_addr   = caddr;
  assign bus.cpu_wdata  = cwdata;
  assign bus0.cpu_req   = req;
  assign bus0.cpu_we    = cwe;
  assign bus0.cpu_addr  = caddr;
  assign bus0.cpu_wdata = cwdata;

  // SRAM models, one per DUT
  logic [15:0] sram  [0:255] = '{default: 16'h0000};
  logic [15:0] sram0 [0:255] = '{default: 16'h0000};
  assign bus.mem_rdata  = sram[bus.mem_addr[7:0]];
  assign bus0.mem_rdata = sram0[bus0.mem_addr[7:0]];
  always @(posedge clk) if (!bus.mem_ce_n && !bus.mem_we_n) sram[bus.mem_addr[7:0]] <= bus.mem_wdata;
  always @(posedge clk) if (!bus0.mem_ce_n && !bus0.mem_we_n) sram0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;

  logic        ack_s, ce_s, oe_s, wn_s;
  logic [15:0] rdata_s, maddr_s;
  assign ack_s   = sel ? bus0.cpu_ack   : bus.cpu_ack;
  assign ce_s    = sel ? bus0.mem_ce_n  : bus.mem_ce_n;
  assign oe_s    = sel ? bus0.mem_oe_n  : bus.mem_oe_n;
  assign wn_s    = sel ? bus0.mem_we_n  : bus.mem_we_n;
  assign rdata_s = sel ? bus0.cpu_rdata : bus.cpu_rdata;
  assign maddr_s = sel ? bus0.mem_addr  : bus.mem_addr;

  // Reference model state
  logic [15:0] exp_mem [0:255] = '{default: 16'h0000};
  logic [15:0] exp_hex = '0;
  logic [11:0] exp_led = '0;
  logic [15:0] sw_val = '0;
  logic [15:0] last_rd = '0;

  int errs = 0;
  int checks = 0;

  function automatic logic [15:0] io_read(input logic [15:0] a);
    if (a == SW_A) return sw_val;
    if (a == HEX_A) return exp_hex;
    return {4'h0, exp_led};
  endfunction

  function automatic bit is_io(input logic [15:0] a);
    return (a == SW_A) || (a == HEX_A) || (a == LED_A);
  endfunction

  // One request on the selected DUT; reports latency and strobe-low cycle counts.
  task automatic txn(input bit s, input bit we, input logic [15:0] a, input logic [15:0] d,
                     input bit scramble, output logic [15:0] rd, output int lat,
                     output int ce, output int oe, output int wn, output int badaddr);
    lat = 0; ce = 0; oe = 0; wn = 0; badaddr = 0; rd = '0;
    @(negedge clk);
    sel = s; req = 1'b1; cwe = we; caddr = a; cwdata = d;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (scramble && n == 1) begin
        caddr = 16'($urandom); cwdata = 16'($urandom); cwe = 1'($urandom);
      end
      if (!ce_s) begin
        ce++;
        if (maddr_s !== a) badaddr++;
      end
      if (!oe_s) oe++;
      if (!wn_s) wn++;
      if (ack_s) begin
        lat = n; rd = rdata_s;
        break;
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_switches(input logic [15:0] v);
    @(negedge clk);
    switches = v; sw_val = v;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.cpu_ack, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 4'b0111) begin
      errs++; $display("FAIL reset_ctrl ack/ce/oe/we got %b want 0111",
                       {bus.cpu_ack, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n});
    end
    checks++;
    if ({hex_out, led, bus.cpu_rdata} !== 44'h0) begin
      errs++; $display("FAIL reset_regs hex=%h led=%h rdata=%h want 0", hex_out, led, bus.cpu_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_mem_read();
    logic [15:0] rd; int lat, ce, oe, wn, ba;
    txn(0, 1'b1, 16'h0040, 16'h1234, 0, rd, lat, ce, oe, wn, ba);
    exp_mem[8'h40] = 16'h1234;
    checks++;
    if ({lat, ce, oe, wn} !== {32'd3, 32'd2, 32'd0, 32'd2}) begin
      errs++; $display("FAIL mem_write lat/ce/oe/we got %0d/%0d/%0d/%0d want 3/2/0/2", lat, ce, oe, wn);
    end
    txn(0, 1'b0, 16'h0040, 16'h0000, 0, rd, lat, ce, oe, wn, ba);
    checks++;
    if ({lat, ce, oe, wn, ba} !== {32'd3, 32'd2, 32'd2, 32'd0, 32'd0}) begin
      errs++; $display("FAIL mem_read lat/ce/oe/we/badaddr got %0d/%0d/%0d/%0d/%0d want 3/2/2/0/0",
                       lat, ce, oe, wn, ba);
    end
    checks++;
    if (rd !== 16'h1234) begin
      errs++; $display("FAIL mem_read_data got %h want 1234", rd);
    end
    last_rd = 16'h1234;
  endtask

  task automatic test_io();
    logic [15:0] rd; int lat, ce, oe, wn, ba;
    set_switches(16'hBEEF);
    txn(0, 1'b0, SW_A, 16'h0000, 0, rd, lat, ce, oe, wn, ba);
    checks++;
    if (lat !== 1 || ce !== 0 || rd !== 16'hBEEF) begin
      errs++; $display("FAIL sw_read lat=%0d ce=%0d data=%h want 1/0/beef", lat, ce, rd);
    end
    last_rd = 16'hBEEF;
    txn(0, 1'b1, HEX_A, 16'hCAFE, 0, rd, lat, ce, oe, wn, ba);
    exp_hex = 16'hCAFE;
    checks++;
    if (lat !== 1 || ce !== 0 || hex_out !== 16'hCAFE) begin
      errs++; $display("FAIL hex_write lat=%0d ce=%0d hex=%h want 1/0/cafe", lat, ce, hex_out);
    end
    checks++;
    if (bus.cpu_rdata !== last_rd) begin
      errs++; $display("FAIL rdata_hold got %h want %h", bus.cpu_rdata, last_rd);
    end
  endtask

  task automatic test_led();
    logic [15:0] rd; int lat, ce, oe, wn, ba;
    txn(0, 1'b1, LED_A, 16'hFFFF, 0, rd, lat, ce, oe, wn, ba);
    exp_led = 12'hFFF;
    checks++;
    if (lat !== 1 || led !== 12'hFFF) begin
      errs++; $display("FAIL led_write lat=%0d led=%h want 1/fff", lat, led);
    end
    txn(0, 1'b0, LED_A, 16'h0000, 0, rd, lat, ce, oe, wn, ba);
    checks++;
    if (lat !== 1 || rd !== 16'h0FFF) begin
      errs++; $display("FAIL led_read lat=%0d data=%h want 1/0fff", lat, rd);
    end
    last_rd = 16'h0FFF;
  endtask

  task automatic test_back_to_back();
    int a1 = 0, a2 = 0, nack = 0;
    logic [15:0] rd1 = '0, rd2 = '0;
    set_switches(16'h1357);
    @(negedge clk);
    sel = 1'b0; req = 1'b1; cwe = 1'b0; caddr = LED_A;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack) begin
        nack++;
        if (a1 == 0) begin
          a1 = n; rd1 = bus.cpu_rdata; caddr = SW_A;
        end else begin
          a2 = n; rd2 = bus.cpu_rdata;
          break;
        end
      end
    end
    req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a1 !== 1 || a2 !== 3 || nack !== 2) begin
      errs++; $display("FAIL b2b_timing ack1=%0d ack2=%0d acks=%0d want 1/3/2", a1, a2, nack);
    end
    checks++;
    if (rd1 !== {4'h0, exp_led} || rd2 !== 16'h1357) begin
      errs++; $display("FAIL b2b_data got %h/%h want %h/1357", rd1, rd2, {4'h0, exp_led});
    end
    last_rd = 16'h1357;
  endtask

  task automatic test_random();
    logic [15:0] rd, a, d, exp_rd;
    int lat, ce, oe, wn, ba, elat, ece, eoe, ewn;
    bit we, io;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) set_switches(16'($urandom));
      case ($urandom_range(0, 3))
        0, 1:    a = {8'h00, 8'($urandom)};
        2:       a = LED_A;
        default: a = SW_A;
      endcase
      we = (i == 0) ? 1'b0 : 1'($urandom);
      d  = 16'($urandom);
      io = is_io(a);
      txn(0, we, a, d, 1, rd, lat, ce, oe, wn, ba);
      elat = io ? 1 : WS + 2;
      ece  = io ? 0 : WS + 1;
      eoe  = (!io && !we) ? WS + 1 : 0;
      ewn  = (!io && we) ? WS + 1 : 0;
      checks++;
      if ({lat, ce, oe, wn, ba} !== {elat, ece, eoe, ewn, 32'd0}) begin
        errs++; $display("FAIL rand_timing a=%h we=%0d got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/0",
                         a, we, lat, ce, oe, wn, ba, elat, ece, eoe, ewn);
      end
      if (!we) begin
        exp_rd = io ? io_read(a) : exp_mem[a[7:0]];
        checks++;
        if (rd !== exp_rd) begin
          errs++; $display("FAIL rand_read a=%h got %h want %h", a, rd, exp_rd);
        end
        last_rd = exp_rd;
      end else begin
        if (!io) exp_mem[a[7:0]] = d;
        else if (a == HEX_A) exp_hex = d;
        else if (a == LED_A) exp_led = d[11:0];
        checks++;
        if (bus.cpu_rdata !== last_rd || hex_out !== exp_hex || led !== exp_led) begin
          errs++; $display("FAIL rand_write a=%h rdata=%h hex=%h led=%h want %h/%h/%h",
                           a, bus.cpu_rdata, hex_out, led, last_rd, exp_hex, exp_led);
        end
      end
    end
  endtask

  task automatic test_wait0();
    logic [15:0] rd; int lat, ce, oe, wn, ba;
    txn(1, 1'b1, 16'h0010, 16'h00A5, 0, rd, lat, ce, oe, wn, ba);
    checks++;
    if ({lat, ce, oe, wn, ba} !== {32'd2, 32'd1, 32'd0, 32'd1, 32'd0}) begin
      errs++; $display("FAIL ws0_write lat/ce/oe/we/badaddr got %0d/%0d/%0d/%0d/%0d want 2/1/0/1/0",
                       lat, ce, oe, wn, ba);
    end
    txn(1, 1'b0, 16'h0010, 16'h0000, 0, rd, lat, ce, oe, wn, ba);
    checks++;
    if (lat !== 2 || oe !== 1 || rd !== 16'h00A5) begin
      errs++; $display("FAIL ws0_read lat=%0d oe=%0d data=%h want 2/1/00a5", lat, oe, rd);
    end
    // The shared request also drove the WAIT_STATES=1 DUT; let it drain.
    exp_mem[8'h10] = 16'h00A5;
    sel = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset_mid_mem();
    logic [15:0] rd; int lat, ce, oe, wn, ba, nack;
    txn(0, 1'b1, LED_A, 16'h0ABC, 0, rd, lat, ce, oe, wn, ba);
    txn(0, 1'b1, HEX_A, 16'h1111, 0, rd, lat, ce, oe, wn, ba);
    txn(0, 1'b0, HEX_A, 16'h0000, 0, rd, lat, ce, oe, wn, ba);
    checks++;
    if (led !== 12'hABC || hex_out !== 16'h1111 || rd !== sw_val) begin
      errs++; $display("FAIL pre_abort led=%h hex=%h rd=%h want abc/1111/%h", led, hex_out, rd, sw_val);
    end
    @(negedge clk);
    sel = 1'b0; req = 1'b1; cwe = 1'b0; caddr = 16'h0020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_ce_n !== 1'b0) begin
      errs++; $display("FAIL abort_in_mem ce_n=%b want 0", bus.mem_ce_n);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cpu_ack, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 4'b0111 ||
        hex_out !== 16'h0 || led !== 12'h0 || bus.cpu_rdata !== 16'h0) begin
      errs++; $display("FAIL abort_async ctrl=%b hex=%h led=%h rdata=%h want 0111/0/0/0",
                       {bus.cpu_ack, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, hex_out, led, bus.cpu_rdata);
    end
    req = 1'b0;
    nack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.cpu_ack) nack++;
    end
    @(negedge clk); rst_n = 1'b1;
    exp_hex = '0; exp_led = '0; last_rd = '0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.cpu_ack) nack++;
    end
    checks++;
    if (nack !== 0 || bus.cpu_rdata !== 16'h0) begin
      errs++; $display("FAIL abort_no_ack acks=%0d rdata=%h want 0/0", nack, bus.cpu_rdata);
    end
    txn(0, 1'b0, 16'h0020, 16'h0000, 0, rd, lat, ce, oe, wn, ba);
    checks++;
    if (lat !== WS + 2 || oe !== WS + 1 || rd !== exp_mem[8'h20]) begin
      errs++; $display("FAIL post_reset_read lat=%0d oe=%0d data=%h want %0d/%0d/%h",
                       lat, oe, rd, WS + 2, WS + 1, exp_mem[8'h20]);
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io();
    test_led();
    test_back_to_back();
    test_random();
    test_wait0();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16: CPU/memory data width.
REQ-002 SHALL have parameter ADDR_W, default 16: address width.
REQ-003 SHALL have parameter NUM_HEX, default 4: hex digits driven; legal range 1..DATA_W/4.
REQ-004 SHALL have parameter LED_W, default 12: LED register width; legal range 1..DATA_W.
REQ-005 SHALL have parameter WAIT_STATES, default 1: extra memory strobe cycles; legal range 0..15.
REQ-006 SHALL have parameters SW_ADDR, default all-ones; HEX_ADDR, default all-ones; LED_ADDR, default all-ones minus 1. These are the I/O addresses.
REQ-007 Clk  in  1  sole clock, rising edge.
REQ-008 Reset  in  1  asynchronous, active-low.
REQ-009 cpu_req  in  1  transaction request, held until cpu_ack.
REQ-010 cpu_we  in  1  1 = write, 0 = read.
REQ-011 cpu_addr  in  ADDR_W  transaction address.
REQ-012 cpu_wdata  in  DATA_W  write data.
REQ-013 cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high.
REQ-014 cpu_ack  out  1  one-cycle completion pulse.
REQ-015 mem_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low SRAM strobes.
REQ-016 mem_addr  out  ADDR_W  memory address.
REQ-017 mem_wdata  out  DATA_W  memory write data.
REQ-018 mem_rdata  in  DATA_W  memory read data.
REQ-019 switches  in  DATA_W  asynchronous board switches.
REQ-020 hex_out  out  4*NUM_HEX  hex digit register; digit i = bits [4i+3:4i].
REQ-021 led  out  LED_W  LED register.

Function
REQ-022 The FSM SHALL have the states IDLE, MEM, ACK.
- IDLE with cpu_req=1: latch cpu_addr, cpu_we and cpu_wdata.
- SW_ADDR, HEX_ADDR or LED_ADDR → ACK.
- Any other address → MEM.
REQ-023 I/O read latency SHALL be 1 cycle: cpu_ack is high in the cycle after cpu_req is sampled.
REQ-024 In MEM, mem_ce_n SHALL be 0 for exactly WAIT_STATES+1 cycles. mem_oe_n=0 on a read; mem_we_n=0 on a write.
REQ-025 The last MEM cycle SHALL register mem_rdata into cpu_rdata and go to ACK. Total memory latency = WAIT_STATES+2 cycles from request sample to cpu_ack.
REQ-026 ACK SHALL assert cpu_ack for one cycle, then return to IDLE. A request held high after the ack is sampled no earlier than the cycle after ACK (one idle cycle minimum).
REQ-027 In IDLE, cpu_req, cpu_addr, cpu_we and cpu_wdata SHALL NOT be sampled when cpu_req=0. Changes to them in MEM/ACK SHALL be ignored.
REQ-028 Read at SW_ADDR SHALL return the 2-flop-synchronised switches value.
REQ-029 Write at SW_ADDR SHALL be discarded but still acknowledged.
REQ-030 Write at HEX_ADDR SHALL load hex_out ← cpu_wdata[4*NUM_HEX-1:0]. Read at HEX_ADDR SHALL return hex_out zero-extended.
REQ-031 When SW_ADDR == HEX_ADDR (default), reads SHALL return switches and writes SHALL go to hex_out.
REQ-032 LED_ADDR write SHALL load led ← cpu_wdata[LED_W-1:0]. Read SHALL return led zero-extended.
REQ-033 mem_addr and mem_wdata SHALL be driven from the latched request. All strobes SHALL be 1 outside MEM.
REQ-034 The wait counter SHALL be $clog2(WAIT_STATES+2) bits wide. It SHALL load WAIT_STATES on MEM entry and count down to 0.
REQ-035 cpu_rdata SHALL hold its last value between transactions. Writes SHALL leave cpu_rdata unchanged.

Reset
REQ-036 Reset=0 SHALL immediately force, independent of Clk:
- state IDLE;
- cpu_ack=0;
- all mem_*_n=1;
- cpu_rdata=0, hex_out=0, led=0;
- synchroniser flops=0;
- wait counter=0.
REQ-037 Reset asserted mid-MEM SHALL abort the transaction: no ack and no register update. After release, the first cycle with cpu_req=1 SHALL be treated as a new request.

Structure
REQ-038 A shared package mmio_pkg SHALL hold:
- the state enum (IDLE, MEM, ACK);
- default address constants MMIO_SW_ADDR and MMIO_LED_ADDR.
REQ-039 A sub-module sync2 (parametrised width, async active-low reset) SHALL implement the switch synchroniser. It is the only sub-module.

Verification
REQ-040 Read 0x1234 at memory address 0x0040, WAIT_STATES=1 → mem_ce_n and mem_oe_n low 2 cycles, cpu_ack 3 cycles after request, cpu_rdata=0x1234.
REQ-041 switches=0xBEEF, read SW_ADDR 4 cycles later → cpu_ack after 1 cycle, cpu_rdata=0xBEEF. Write 0xCAFE to 0xFFFF → hex_out=0xCAFE, no memory strobe.
REQ-042 Write 0xFFFF to LED_ADDR with LED_W=12 → led=0xFFF. Read back → cpu_rdata=0x0FFF.
REQ-043 WAIT_STATES=0, memory write 0x00A5 to 0x0010 → mem_we_n low exactly 1 cycle, ack 2 cycles after request.
REQ-044 Reset pulled low in the second MEM cycle → strobes high the same cycle, no cpu_ack, hex_out/led=0. A new read after release completes normally.
REQ-045 Back-to-back: cpu_req held high across two reads → second request sampled in the IDLE cycle after the ack, both acks separated by ≥1 cycle.
